// File: rtl/riscv_mem_pkg.sv
// Shared types for the RV32I data-memory path: access sizes, responder states, byte enables.
// Latency: n/a (types and a pure function only).
// Backpressure: n/a.
package riscv_mem_pkg;

  // Access width, encoded as funct3[1:0] of the load/store instruction
  typedef enum logic [1:0] {
    SZ_B = 2'd0,
    SZ_H = 2'd1,
    SZ_W = 2'd2,
    SZ_X = 2'd3
  } mem_size_e;

  typedef enum logic [1:0] {
    RS_IDLE = 2'd0,
    RS_WAIT = 2'd1,
    RS_RESP = 2'd2
  } resp_state_e;

  // Byte enables for an access of the given size at the given lane offset
  function automatic logic [3:0] be_from_size(input mem_size_e size, input logic [1:0] addr_lo);
    logic [3:0] be;
    case (size)
      SZ_B:    be = 4'b0001 << addr_lo;
      SZ_H:    be = addr_lo[1] ? 4'b1100 : 4'b0011;
      SZ_W:    be = 4'b1111;
      default: be = 4'b0000;
    endcase
    return be;
  endfunction

endpackage

// File: rtl/load_ext.sv
// Load lane select plus sign/zero extension of a 32-bit memory word.
// Latency: combinational.
// Backpressure: none (pure function of its inputs).
import riscv_mem_pkg::*;

module load_ext (
  input  logic [31:0] word,
  input  logic [1:0]  addr_lo,
  input  logic [1:0]  size,
  input  logic        is_unsigned,
  output logic [31:0] result
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  assign byte_sel = word[{addr_lo, 3'b000} +: 8];
  assign half_sel = addr_lo[1] ? word[31:16] : word[15:0];

  // Extend the selected lane; an illegal size yields zero (flagged as an error upstream)
  always_comb begin
    result = '0;
    case (mem_size_e'(size))
      SZ_B:    result = {{24{~is_unsigned & byte_sel[7]}}, byte_sel};
      SZ_H:    result = {{16{~is_unsigned & half_sel[15]}}, half_sel};
      SZ_W:    result = word;
      default: result = '0;
    endcase
  end

endmodule

// File: rtl/dmem_responder.sv
// Single-outstanding data-memory responder with wait states, lane steering and error checks.
// Latency: accept edge N -> rsp_valid in cycle N+1+WAIT_CYC; req_ready returns the cycle after the response handshake.
// Backpressure: holds the response (outputs frozen) while rsp_ready is low; req_ready is low outside IDLE.
import riscv_mem_pkg::*;

module dmem_responder #(
  parameter int          DEPTH_WORDS = 64,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int          WAIT_CYC    = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int          AW        = $clog2(DEPTH_WORDS);
  localparam logic [31:0] WIN_BYTES = 32'(DEPTH_WORDS * 4);
  localparam logic [3:0]  WAIT_LOAD = (WAIT_CYC > 0) ? 4'(WAIT_CYC - 1) : 4'd0;

  resp_state_e state, state_nxt;
  logic        enter_resp;
  logic        accept;
  logic [3:0]  wait_cnt;

  logic [31:0] mem [DEPTH_WORDS];

  // Captured request
  logic [31:0] op_addr, op_wdata;
  logic [1:0]  op_size;
  logic        op_uns, op_we;

  // Operands of the access being executed: live inputs when going straight from IDLE
  logic [31:0] cur_addr, cur_wdata, cur_off;
  logic [1:0]  cur_size;
  logic        cur_uns, cur_we, cur_err;
  logic [AW-1:0] cur_idx;
  logic [3:0]  cur_be;
  logic [31:0] wr_lanes, ld_word, ld_data;

  assign req_ready = (state == RS_IDLE);
  assign rsp_valid = (state == RS_RESP);
  assign accept    = req_valid & req_ready;

  assign cur_addr  = (state == RS_IDLE) ? req_addr     : op_addr;
  assign cur_wdata = (state == RS_IDLE) ? req_wdata    : op_wdata;
  assign cur_size  = (state == RS_IDLE) ? req_size     : op_size;
  assign cur_uns   = (state == RS_IDLE) ? req_unsigned : op_uns;
  assign cur_we    = (state == RS_IDLE) ? req_we       : op_we;

  // Unsigned offset: addresses below the window wrap high and fail the range test
  assign cur_off = cur_addr - BASE_ADDR;
  assign cur_idx = cur_off[AW+1:2];
  assign cur_be  = be_from_size(mem_size_e'(cur_size), cur_off[1:0]);
  assign cur_err = (cur_size == SZ_X)
                 | ((cur_size == SZ_H) & cur_addr[0])
                 | ((cur_size == SZ_W) & (cur_addr[1:0] != 2'b00))
                 | (cur_off >= WIN_BYTES);
  assign ld_word = mem[cur_idx];

  // Replicate store data across lanes so the byte enables pick the right copy
  always_comb begin
    wr_lanes = cur_wdata;
    case (mem_size_e'(cur_size))
      SZ_B:    wr_lanes = {4{cur_wdata[7:0]}};
      SZ_H:    wr_lanes = {2{cur_wdata[15:0]}};
      default: wr_lanes = cur_wdata;
    endcase
  end

  load_ext u_load_ext (
    .word        (ld_word),
    .addr_lo     (cur_off[1:0]),
    .size        (cur_size),
    .is_unsigned (cur_uns),
    .result      (ld_data)
  );

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= RS_IDLE;
    else       state <= state_nxt;
  end

  // Next state; enter_resp marks the edge on which memory is read or written
  always_comb begin
    state_nxt  = state;
    enter_resp = 1'b0;
    case (state)
      RS_IDLE: begin
        if (req_valid) begin
          if (WAIT_CYC == 0) begin
            state_nxt  = RS_RESP;
            enter_resp = 1'b1;
          end else begin
            state_nxt = RS_WAIT;
          end
        end
      end
      RS_WAIT: begin
        if (wait_cnt == 4'd0) begin
          state_nxt  = RS_RESP;
          enter_resp = 1'b1;
        end
      end
      RS_RESP: begin
        if (rsp_ready) state_nxt = RS_IDLE;
      end
      default: state_nxt = RS_IDLE;
    endcase
  end

  // Request capture, wait counter and response registers
  always_ff @(posedge clk) begin
    if (reset) begin
      op_addr   <= '0;
      op_wdata  <= '0;
      op_size   <= '0;
      op_uns    <= 1'b0;
      op_we     <= 1'b0;
      wait_cnt  <= '0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      if (accept) begin
        op_addr  <= req_addr;
        op_wdata <= req_wdata;
        op_size  <= req_size;
        op_uns   <= req_unsigned;
        op_we    <= req_we;
        wait_cnt <= WAIT_LOAD;
      end else if ((state == RS_WAIT) && (wait_cnt != 4'd0)) begin
        wait_cnt <= wait_cnt - 4'd1;
      end
      if (enter_resp) begin
        rsp_rdata <= (cur_err | cur_we) ? 32'd0 : ld_data;
        rsp_err   <= cur_err;
      end else if ((state == RS_RESP) && rsp_ready) begin
        rsp_rdata <= '0;
        rsp_err   <= 1'b0;
      end
    end
  end

  // Byte-masked store commit; a reset on the commit edge discards the store
  always_ff @(posedge clk) begin
    if (!reset && enter_resp && cur_we && !cur_err) begin
      for (int b = 0; b < 4; b++) begin
        if (cur_be[b]) mem[cur_idx][8*b +: 8] <= wr_lanes[8*b +: 8];
      end
    end
  end

endmodule
